// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//
// Floor-call scheduler for the three-floor elevator. One-shot floor calls are
// latched into a pending register and served in SCAN order: the car keeps
// moving in its current direction while calls remain ahead of it. Per-floor
// travel time and door dwell are timed here, and the motor on/off and
// direction controls for the stepper driver are produced here.
//
// Parameters
//   TRAVEL_TICKS : clock cycles to move one floor
//   DOOR_TICKS   : clock cycles the door stays open
//   CNT_W        : timer width, 2^CNT_W > max(TRAVEL_TICKS, DOOR_TICKS)
//
// Ports
//   clk          : system clock (clk10k)
//   reset_n      : asynchronous active-low reset
//   call_tick    : single-cycle floor-call pulses, bit i = floor i
//   motor_onoff  : 1 while the car is travelling
//   motor_dir    : 1 = up, 0 = down (meaningful only while motor_onoff = 1)
//   cur_floor    : current or last-passed floor, 0..2
//   door_open    : 1 during door dwell
//   pending      : latched outstanding calls
//   busy         : 1 whenever the scheduler is not idle

module elevator_scheduler #(
    parameter int TRAVEL_TICKS = 50000,
    parameter int DOOR_TICKS   = 30000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] call_tick,
    output logic       motor_onoff,
    output logic       motor_dir,
    output logic [1:0] cur_floor,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic [1:0]       floor_next;
    logic [2:0]       pending_next;
    logic             dir_pref;
    logic             dir_pref_next;
    logic [2:0]       here_mask;
    logic [2:0]       arrive_mask;
    logic [2:0]       latch_mask;
    logic             at_rest;
    logic             same_floor_call;
    logic             above;
    logic             below;

    // Call classification. While the car is standing (idle or door open) a
    // call for the floor it is standing at opens or holds the door instead of
    // becoming a pending request; while moving, every call is simply latched,
    // including one for the floor just left.
    always_comb begin
        here_mask       = 3'b001 << cur_floor;
        at_rest         = (state == IDLE) || (state == DOOR);
        same_floor_call = at_rest && ((call_tick & here_mask) != 3'b000);
        latch_mask      = at_rest ? (call_tick & ~here_mask) : call_tick;
        above           = 1'b0;
        below           = 1'b0;
        case (cur_floor)
            2'd0: above = (pending[2:1] != 2'b00);
            2'd1: begin
                above = pending[2];
                below = pending[0];
            end
            2'd2: below = (pending[1:0] != 2'b00);
            default: begin
                above = 1'b0;
                below = 1'b0;
            end
        endcase
    end

    // Next-state logic. Direction preference only breaks the tie when calls
    // exist on both sides, which keeps the car sweeping in SCAN order. On a
    // floor crossing, a call for the new floor arriving in that very cycle
    // still stops the car, so the arrival check uses the freshly latched set.
    always_comb begin
        state_next    = state;
        timer_next    = timer;
        floor_next    = cur_floor;
        pending_next  = pending | latch_mask;
        dir_pref_next = dir_pref;
        arrive_mask   = here_mask;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (same_floor_call) begin
                    state_next = DOOR;
                end else if (above && (dir_pref || !below)) begin
                    state_next    = MOVE_UP;
                    dir_pref_next = 1'b1;
                end else if (below) begin
                    state_next    = MOVE_DOWN;
                    dir_pref_next = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (((state == MOVE_UP) && (cur_floor >= 2'd2)) ||
                    ((state == MOVE_DOWN) && (cur_floor == 2'd0))) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == TRAVEL_LAST) begin
                    floor_next  = (state == MOVE_UP) ? (cur_floor + 2'd1) : (cur_floor - 2'd1);
                    arrive_mask = 3'b001 << floor_next;
                    timer_next  = '0;
                    if ((pending_next & arrive_mask) != 3'b000) begin
                        pending_next = pending_next & ~arrive_mask;
                        state_next   = DOOR;
                    end
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            DOOR: begin
                if (same_floor_call) begin
                    timer_next = '0;
                end else if (timer == DOOR_LAST) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // State and output registers. Outputs are decoded from the next state so
    // they change on the same edge as the state itself, e.g. motor_onoff
    // falls and door_open rises together on the arrival edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_floor   <= 2'd0;
            pending     <= 3'b000;
            timer       <= '0;
            dir_pref    <= 1'b1;
            motor_onoff <= 1'b0;
            motor_dir   <= 1'b0;
            door_open   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cur_floor   <= floor_next;
            pending     <= pending_next;
            timer       <= timer_next;
            dir_pref    <= dir_pref_next;
            motor_onoff <= (state_next == MOVE_UP) || (state_next == MOVE_DOWN);
            motor_dir   <= (state_next == MOVE_UP);
            door_open   <= (state_next == DOOR);
            busy        <= (state_next != IDLE);
        end
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Floor-call scheduler for the three-floor elevator. It latches one-shot floor-call pulses into a pending-request register and serves them in SCAN order: it keeps travelling in the current direction while calls remain ahead. It times per-floor travel and door dwell, and drives the motor on/off and direction controls that feed `step_motor`. It also exports the current floor and door status to the 7-segment controller. It sits in the `clk10k` domain, between the `oneshot` outputs and the motor/display blocks.

## Interface
- `TRAVEL_TICKS`, default 50000: clock cycles to move one floor (5 s at 10 kHz).
- `DOOR_TICKS`, default 30000: clock cycles the door stays open (3 s).
- `CNT_W`, default 16: timer width. Must satisfy 2^CNT_W > max(TRAVEL_TICKS, DOOR_TICKS).
- `clk` in 1: system clock (`clk10k`).
- `reset_n` in 1: asynchronous, active-low reset.
- `call_tick` in 3: single-cycle floor-call pulses. Bit i is a call to floor i (0 = ground).
- `motor_onoff` out 1: 1 while the car is travelling.
- `motor_dir` out 1: 1 = up, 0 = down. Valid only when `motor_onoff` = 1.
- `cur_floor` out 2: current or last-passed floor, 0..2.
- `door_open` out 1: 1 during door dwell.
- `pending` out 3: latched outstanding calls.
- `busy` out 1: 1 whenever the state is not IDLE.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. All outputs are registered.
- Reset values: state IDLE, `cur_floor` 0, `pending` 0, timer 0, `dir_pref` up, `motor_onoff` 0, `motor_dir` 0, `door_open` 0, `busy` 0.
- Definitions:
  - `above` = any pending bit with index > `cur_floor`.
  - `below` = any pending bit with index < `cur_floor`.
- Call latching, evaluated every cycle for each asserted `call_tick[i]`:
  - i == `cur_floor` while in IDLE: do not set pending. Go to DOOR and clear the timer.
  - i == `cur_floor` while in DOOR: do not set pending. Restart the timer at 0 (door held open).
  - Any other case, including i == `cur_floor` while moving: set `pending[i]`. Repeated calls are idempotent.
- Multiple bits in one cycle are all latched.
- IDLE, when no call above applies:
  - If `above` and (`dir_pref` up or not `below`): go to MOVE_UP and set `dir_pref` up.
  - Else if `below`: go to MOVE_DOWN and set `dir_pref` down.
  - Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - The timer increments each cycle.
  - When timer == TRAVEL_TICKS-1: `cur_floor` ±1, timer cleared.
  - If `pending[new floor]` is set (or `call_tick` for that floor in the same cycle): clear that bit and go to DOOR.
  - Otherwise continue in the same direction. A request ahead is guaranteed to exist.
- DOOR:
  - The timer increments each cycle.
  - At DOOR_TICKS-1: go to IDLE with the timer cleared. `dir_pref` is retained.
- `cur_floor` never leaves 0..2. A MOVE_UP at floor 2 or MOVE_DOWN at floor 0 is unreachable. If it is ever entered, go to IDLE.
- An asynchronous reset mid-operation returns every register to its reset value immediately. Pending calls are discarded.

## Timing
- `call_tick` to `pending` bit set: 1 cycle.
- IDLE with work to `motor_onoff` = 1: 1 cycle.
  - `motor_dir` is valid in the same cycle as `motor_onoff`.
  - `busy` rises with the state change.
- Travel time per floor: exactly TRAVEL_TICKS cycles of `motor_onoff` = 1.
- A pass-through floor shows no gap: `motor_onoff` stays high across it, and `cur_floor` updates on the crossing cycle.
- Arrival cycle: `motor_onoff` falls, `door_open` rises and `pending` bit clears, all on the same clock edge.
- Door dwell: exactly DOOR_TICKS cycles of `door_open` = 1. After that, 1 cycle in IDLE before the next move.
- Door reopen by a same-floor call in DOOR: `door_open` stays high for DOOR_TICKS cycles after the last call.

## Test plan
All scenarios use TRAVEL_TICKS=10 and DOOR_TICKS=5.
- Reset then idle: all outputs 0, `cur_floor` 0. A `call_tick`=001 pulse gives `door_open` high for 5 cycles, `pending` stays 000, and no motor activity.
- Single call up: pulse 100 at floor 0.
  - Expected: `motor_onoff`=1 and `motor_dir`=1 for 20 cycles.
  - `cur_floor` goes 1 at cycle 10, then 2 at cycle 20. `motor_onoff` does not drop at floor 1.
  - Then `door_open` for 5 cycles and `pending` returns to 000.
- SCAN order: at floor 1 moving up toward 2, pulse 001 mid-travel.
  - Expected: serve floor 2 first (door), then IDLE for 1 cycle, then MOVE_DOWN to floor 0 for 20 cycles.
- Simultaneous calls: pulse 110 in a single cycle at floor 0.
  - Expected: stop at floor 1 (door 5 cycles, `pending`=100), then continue to floor 2.
- Door hold: in DOOR at floor 2, pulse 100 at dwell cycle 3. Expected: `door_open` stays high 5 more cycles, for 9 total.
- Reset mid-travel: assert `reset_n`=0 during MOVE_UP with `pending`=100. Expected: immediately `motor_onoff`=0, `pending`=000, `cur_floor`=0, state IDLE.
